dds_multi_nco: RTL and testbench

//  Multi-channel numerically controlled oscillator. NCH phase accumulators advance on a shared tick.

---
 rtl/dds_pkg.sv | 15 +
 rtl/dds_multi_nco_if.sv | 20 ++
 rtl/dds_sine_rom.sv | 39 +++
 rtl/dds_multi_nco.sv | 73 +++++++
 tb/tb_dds_multi_nco.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared encodings, scan state and width helpers for the multi-channel NCO
package dds_pkg;
  localparam logic [1:0] CFG_STEP = 2'd0;
  localparam logic [1:0] CFG_PHASE = 2'd1;
  localparam logic [1:0] CFG_DIR = 2'd2;
  typedef enum logic {IDLE, SCAN} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int ch_w(input int n);
    return n > 2 ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dds_multi_nco_if.sv
// dds_multi_nco_if: tick/config bus in, serial sample stream and status out
interface dds_multi_nco_if #(
  parameter int NCH = 4,
  parameter int PHASE_W = 16,
  parameter int DATA_W = 20
);
  localparam int CH_W = dds_pkg::ch_w(NCH);
  logic tick;
  logic cfg_we;
  logic [1:0] cfg_sel;
  logic [CH_W-1:0] cfg_ch;
  logic [PHASE_W-1:0] cfg_data;
  logic out_valid;
  logic [CH_W-1:0] out_ch;
  logic [DATA_W-1:0] out_data;
  logic busy;
  logic tick_drop;
  modport master(output tick, cfg_we, cfg_sel, cfg_ch, cfg_data, input out_valid, out_ch, out_data, busy, tick_drop);
  modport slave(input tick, cfg_we, cfg_sel, cfg_ch, cfg_data, output out_valid, out_ch, out_data, busy, tick_drop);
endinterface

// File: rtl/dds_sine_rom.sv
// dds_sine_rom: quarter-wave fold, registered sine table read and sign/offset stage (3 registers)
module dds_sine_rom #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20,
  parameter int OFFSET_BIN = 1
) (
  input logic clk,
  input logic reset,
  input logic [ADDR_W-1:0] p,
  output logic [DATA_W-1:0] data
);
  localparam int QN = 1 << (ADDR_W - 2);
  localparam int MW = DATA_W - 1;
  localparam real PI = 3.14159265358979323846;
  logic [MW-1:0] rom [QN];
  logic [ADDR_W-3:0] m;
  logic neg1, neg2;
  logic [MW-1:0] mag;
  logic [DATA_W-1:0] s;
  // table is built at elaboration: half-sample-offset first quadrant, rounded to nearest
  for (genvar j = 0; j < QN; j++) begin : g_rom
    assign rom[j] = MW'($rtoi($sin(2.0 * PI * ($itor(j) + 0.5) / $itor(1 << ADDR_W)) * $itor((1 << MW) - 1) + 0.5));
  end
  assign s = neg2 ? -{1'b0, mag} : {1'b0, mag};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      m <= '0;
      neg1 <= 1'b0;
      neg2 <= 1'b0;
      mag <= '0;
      data <= '0;
    end else begin
      m <= p[ADDR_W-2] ? ~p[ADDR_W-3:0] : p[ADDR_W-3:0];
      neg1 <= p[ADDR_W-1];
      mag <= rom[m];
      neg2 <= neg1;
      data <= OFFSET_BIN != 0 ? {~s[DATA_W-1], s[DATA_W-2:0]} : s;
    end
endmodule

// File: rtl/dds_multi_nco.sv
// dds_multi_nco: NCH phase accumulators on a shared tick, scanned serially through one sine ROM
module dds_multi_nco
  import dds_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PHASE_W = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20,
  parameter int OFFSET_BIN = 1
) (
  input logic clk,
  input logic reset,
  dds_multi_nco_if.slave bus
);
  localparam int CH_W = ch_w(NCH);
  logic [PHASE_W-1:0] phase [NCH];
  logic [PHASE_W-1:0] step [NCH];
  logic [NCH-1:0] dir;
  logic [NCH-1:0] sel;
  state_t state, state_n;
  logic [CH_W-1:0] idx, idx_n;
  logic [2:0] vld;
  logic [CH_W-1:0] chd [3];
  logic go, last;
  assign go = bus.tick && state == IDLE;
  assign last = 32'(idx) == NCH - 1;
  always_comb begin
    sel = '0;
    for (int c = 0; c < NCH; c++) sel[c] = bus.cfg_we && 32'(bus.cfg_ch) == c;
  end
  // a preload on the tick edge overrides that channel's accumulation
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        phase[c] <= '0;
        step[c] <= '0;
      end
      dir <= '1;
    end else
      for (int c = 0; c < NCH; c++) begin
        if (sel[c] && bus.cfg_sel == CFG_PHASE) phase[c] <= bus.cfg_data;
        else if (go) phase[c] <= dir[c] ? phase[c] + step[c] : phase[c] - step[c];
        if (sel[c] && bus.cfg_sel == CFG_STEP) step[c] <= bus.cfg_data;
        if (sel[c] && bus.cfg_sel == CFG_DIR) dir[c] <= bus.cfg_data[0];
      end
  always_comb begin
    state_n = state == IDLE ? (bus.tick ? SCAN : IDLE) : (last ? IDLE : SCAN);
    idx_n = state == SCAN && !last ? idx + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      vld <= '0;
      chd <= '{default: '0};
      bus.tick_drop <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      vld <= {vld[1:0], state == SCAN};
      chd <= '{idx, chd[0], chd[1]};
      bus.tick_drop <= bus.tick && state == SCAN;
    end
  assign bus.busy = state == SCAN;
  assign bus.out_valid = vld[2];
  assign bus.out_ch = chd[2];
  dds_sine_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_BIN(OFFSET_BIN)) u_rom (
    .clk(clk),
    .reset(reset),
    .p(phase[idx][PHASE_W-1 -: ADDR_W]),
    .data(bus.out_data)
  );
endmodule

// File: tb/tb_dds_multi_nco.sv
// tb_dds_multi_nco: directed checks of an offset-binary and a two's-complement NCO driven in lockstep
module tb_dds_multi_nco;
  localparam real PI = 3.14159265358979323846;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [15:0] mph [4];
  logic [15:0] mst [4];
  logic mdir [4];
  logic [19:0] obs [4];
  logic [19:0] obs_s [4];
  always #5 clk = ~clk;
  dds_multi_nco_if #(.NCH(4), .PHASE_W(16), .DATA_W(20)) bus ();
  dds_multi_nco_if #(.NCH(4), .PHASE_W(16), .DATA_W(20)) bs ();
  assign bs.tick = bus.tick;
  assign bs.cfg_we = bus.cfg_we;
  assign bs.cfg_sel = bus.cfg_sel;
  assign bs.cfg_ch = bus.cfg_ch;
  assign bs.cfg_data = bus.cfg_data;
  dds_multi_nco #(.NCH(4), .PHASE_W(16), .ADDR_W(8), .DATA_W(20), .OFFSET_BIN(1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  dds_multi_nco #(.NCH(4), .PHASE_W(16), .ADDR_W(8), .DATA_W(20), .OFFSET_BIN(0)) dut_s (
    .clk(clk), .reset(reset), .bus(bs));
  function automatic logic [19:0] sine(input logic [15:0] ph, input bit ob);
    int i = int'(ph[13:8]);
    int m = ph[14] ? 63 - i : i;
    int mag = $rtoi($sin(2.0 * PI * ($itor(m) + 0.5) / 256.0) * 524287.0 + 0.5);
    logic [19:0] s = ph[15] ? 20'(-mag) : 20'(mag);
    return ob ? s + 20'h80000 : s;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask
  task automatic mupd(input logic [1:0] sel, input logic [1:0] ch, input logic [15:0] d);
    if (sel == 2'd0) mst[ch] = d;
    if (sel == 2'd1) mph[ch] = d;
    if (sel == 2'd2) mdir[ch] = d[0];
  endtask
  task automatic mreset();
    for (int c = 0; c < 4; c++) begin
      mph[c] = '0;
      mst[c] = '0;
      mdir[c] = 1'b1;
    end
  endtask
  task automatic macc();
    for (int c = 0; c < 4; c++) mph[c] = mdir[c] ? mph[c] + mst[c] : mph[c] - mst[c];
  endtask
  task automatic cfg(input logic [1:0] sel, input logic [1:0] ch, input logic [15:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_sel = sel;
    bus.cfg_ch = ch;
    bus.cfg_data = d;
    step_clk();
    bus.cfg_we = 1'b0;
    mupd(sel, ch, d);
  endtask
  task automatic scan(input logic we = 1'b0, input logic [1:0] sel = 2'd0, input logic [1:0] ch = 2'd0,
                      input logic [15:0] d = 16'h0, input logic drop = 1'b0);
    bus.tick = 1'b1;
    bus.cfg_we = we;
    bus.cfg_sel = sel;
    bus.cfg_ch = ch;
    bus.cfg_data = d;
    macc();
    if (we) mupd(sel, ch, d);
    step_clk();
    bus.tick = drop;
    bus.cfg_we = 1'b0;
    chk("busy", bus.busy, 1);
    step_clk();
    bus.tick = 1'b0;
    chk("drop", bus.tick_drop, drop);
    chk("vld_t1", bus.out_valid, 0);
    step_clk();
    chk("drop_t2", bus.tick_drop, 0);
    chk("vld_t2", bus.out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      step_clk();
      obs[k] = bus.out_data;
      obs_s[k] = bs.out_data;
      chk("vld", bus.out_valid, 1);
      chk("vld_s", bs.out_valid, 1);
      chk("ch", bus.out_ch, k);
      chk("dat", bus.out_data, sine(mph[k], 1'b1));
      chk("dat_s", bs.out_data, sine(mph[k], 1'b0));
    end
    step_clk();
    chk("vld_t7", bus.out_valid, 0);
    chk("busy_t7", bus.busy, 0);
  endtask
  initial begin
    bus.tick = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_sel = 2'd0;
    bus.cfg_ch = 2'd0;
    bus.cfg_data = 16'h0;
    mreset();
    #1;
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_dat", bus.out_data, 0);
    chk("rst_dat_s", bs.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_drop", bus.tick_drop, 0);
    repeat (2) step_clk();
    reset = 1'b0;
    step_clk();
    scan();
    for (int k = 0; k < 4; k++) chk("t1_half", obs[k], 20'h81922);
    cfg(2'd0, 2'd0, 16'h0100);
    for (int n = 1; n <= 256; n++) begin
      scan();
      if (n == 'h40) chk("q40", obs[0], 20'hFFFD8);
      if (n == 'h80) chk("q80", obs[0], 20'h7E6DE);
      if (n == 'hC0) begin
        chk("qC0", obs[0], 20'h00028);
        chk("qC0_s", obs_s[0], 20'h80028);
      end
      if (n == 256) chk("q00", obs[0], 20'h81922);
    end
    cfg(2'd1, 2'd1, 16'hFF80);
    cfg(2'd0, 2'd1, 16'h0100);
    cfg(2'd2, 2'd2, 16'h0000);
    cfg(2'd0, 2'd2, 16'h0040);
    cfg(2'd3, 2'd1, 16'h1234);
    scan();
    chk("wrap_up", obs[1], 20'h81922);
    chk("wrap_dn", obs[2], 20'h7E6DE);
    cfg(2'd0, 2'd3, 16'h0010);
    scan(1'b1, 2'd1, 2'd3, 16'h4000);
    chk("preload", obs[3], 20'hFFFD8);
    scan(1'b0, 2'd0, 2'd0, 16'h0, 1'b1);
    scan();
    bus.tick = 1'b1;
    macc();
    step_clk();
    bus.tick = 1'b0;
    repeat (3) step_clk();
    reset = 1'b1;
    #1;
    chk("rst_mid_vld", bus.out_valid, 0);
    chk("rst_mid_dat", bus.out_data, 0);
    step_clk();
    chk("rst_mid_vld2", bus.out_valid, 0);
    chk("rst_mid_vld_s", bs.out_valid, 0);
    chk("rst_mid_busy", bus.busy, 0);
    reset = 1'b0;
    mreset();
    step_clk();
    scan();
    for (int k = 0; k < 4; k++) chk("post_rst", obs[k], 20'h81922);
    cfg(2'd0, 2'd0, 16'h4000);
    scan();
    chk("s40", obs_s[0], 20'h7FFD8);
    scan();
    chk("s80", obs_s[0], 20'hFE6DE);
    scan();
    chk("sC0", obs_s[0], 20'h80028);
    scan();
    chk("s00", obs_s[0], 20'h01922);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
